elementwise_multiplication: RTL and testbench

//   Registered element-wise (Hadamard) product of two N-element vectors, each element N bits

---
 rtl/elementwise_multiplication_pkg.sv | 11 +
 rtl/elementwise_multiplication_if.sv | 23 ++
 rtl/elementwise_multiplication_lane.sv | 30 +++
 rtl/elementwise_multiplication.sv | 40 ++++
 tb/tb_elementwise_multiplication.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elementwise_multiplication_pkg.sv
// Shared widths and element/product types for the element-wise multiply datapath.
// Default configuration: N lanes, each holding an N-bit operand.
package elementwise_pkg;

  localparam int DEFAULT_N = 8;
  localparam int PROD_W    = 2 * DEFAULT_N;

  typedef logic [DEFAULT_N-1:0] elem_t;
  typedef logic [PROD_W-1:0]    prod_t;

endpackage : elementwise_pkg

// File: rtl/elementwise_multiplication_if.sv
// Operand/result bundle for the element-wise multiplier.
// The master drives the operand pair; the slave returns the registered products.
interface elementwise_multiplication_if #(
  parameter int N = 8
);

  logic           in_valid;
  logic [N-1:0]   a      [0:N-1];
  logic [N-1:0]   b      [0:N-1];
  logic           out_valid;
  logic [2*N-1:0] result [0:N-1];

  modport master (
    output in_valid, a, b,
    input  out_valid, result
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, result
  );

endinterface : elementwise_multiplication_if

// File: rtl/elementwise_multiplication_lane.sv
// One unsigned multiply lane: full-width product registered on valid input,
// held otherwise, so idle operands (even X) never reach the output.
module ew_mul_lane #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod
);

  logic [2*W-1:0] prod_reg;
  logic [2*W-1:0] prod_next;

  // Zero-extend both operands so the multiply is evaluated at full product width.
  assign prod_next = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg <= '0;
    end else if (in_valid) begin
      prod_reg <= prod_next;
    end
  end

  assign prod = prod_reg;

endmodule : ew_mul_lane

// File: rtl/elementwise_multiplication.sv
// Registered Hadamard product of two N-element unsigned vectors, one-cycle latency,
// one pair accepted per clock.
module elementwise_multiplication
  import elementwise_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input logic                         clk,
  input logic                         rst,
  elementwise_multiplication_if.slave bus
);

  logic out_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
    end
  end

  assign bus.out_valid = out_valid_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      ew_mul_lane #(
        .W(N)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .a        (bus.a[gi]),
        .b        (bus.b[gi]),
        .prod     (bus.result[gi])
      );
    end
  endgenerate

endmodule : elementwise_multiplication

// File: tb/tb_elementwise_multiplication.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model of the vector multiplier.
module tb_elementwise_multiplication;

  localparam int N = 8;

  logic clk;
  logic rst;

  elementwise_multiplication_if #(.N(N)) bus ();

  elementwise_multiplication #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Reference state: what the outputs should show after the most recent edge.
  logic [2*N-1:0] m_res [N];
  logic           m_valid;

  // Advance one clock; the model consumes the inputs presented before the edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      for (int i = 0; i < N; i++) m_res[i] = '0;
    end else begin
      m_valid = bus.in_valid;
      if (bus.in_valid) begin
        for (int i = 0; i < N; i++) begin
          int p;
          p = int'(bus.a[i]) * int'(bus.b[i]);
          m_res[i] = p[2*N-1:0];
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input int av [N], input int bv [N]);
    bus.in_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.a[i] = av[i][N-1:0];
      bus.b[i] = bv[i][N-1:0];
    end
  endtask

  task automatic test_reset();
    int z [N];
    for (int i = 0; i < N; i++) z[i] = 0;
    rst = 1'b1;
    drive(1'b0, z, z);
    step();
    step();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got=%0b want=0", bus.out_valid);
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (bus.result[i] !== '0) begin
        fails++;
        $display("FAIL reset_result lane%0d got=%0d want=0", i, bus.result[i]);
      end
    end
    rst = 1'b0;
    $display("[TB] txn reset done");
  endtask

  task automatic test_pattern();
    int av [N];
    int bv [N];
    int ex [N];
    av = '{1, 2, 3, 4, 5, 6, 7, 8};
    bv = '{8, 7, 6, 5, 4, 3, 2, 1};
    ex = '{8, 14, 18, 20, 20, 18, 14, 8};
    drive(1'b1, av, bv);
    step();
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL pattern_valid got=%0b want=1", bus.out_valid);
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (bus.result[i] !== 16'(ex[i])) begin
        fails++;
        $display("FAIL pattern lane%0d got=%0d want=%0d", i, bus.result[i], ex[i]);
      end
    end
    // Scramble idle operands to prove the results hold.
    for (int i = 0; i < N; i++) begin
      av[i] = 200 + i;
      bv[i] = 100 + i;
    end
    drive(1'b0, av, bv);
    step();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_valid got=%0b want=0", bus.out_valid);
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (bus.result[i] !== 16'(ex[i])) begin
        fails++;
        $display("FAIL hold lane%0d got=%0d want=%0d", i, bus.result[i], ex[i]);
      end
    end
    $display("[TB] txn pattern and hold done");
  endtask

  task automatic test_extremes();
    int av [N];
    int bv [N];
    for (int i = 0; i < N; i++) begin
      av[i] = 255;
      bv[i] = 255;
    end
    drive(1'b1, av, bv);
    step();
    for (int i = 0; i < N; i++) begin
      tests++;
      if (bus.result[i] !== 16'hFE01) begin
        fails++;
        $display("FAIL max lane%0d got=%0h want=fe01", i, bus.result[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      av[i] = 0;
      bv[i] = 200;
    end
    drive(1'b1, av, bv);
    step();
    for (int i = 0; i < N; i++) begin
      tests++;
      if (bus.result[i] !== '0) begin
        fails++;
        $display("FAIL zero lane%0d got=%0d want=0", i, bus.result[i]);
      end
    end
    $display("[TB] txn extremes done");
  endtask

  task automatic test_back_to_back();
    int av [N];
    for (int i = 0; i < N; i++) av[i] = 2;
    drive(1'b1, av, av);
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.result[0] !== 16'd4 || bus.result[N-1] !== 16'd4) begin
      fails++;
      $display("FAIL b2b_first valid=%0b r0=%0d r7=%0d want 1/4/4",
               bus.out_valid, bus.result[0], bus.result[N-1]);
    end
    for (int i = 0; i < N; i++) av[i] = 3;
    drive(1'b1, av, av);
    step();
    for (int i = 0; i < N; i++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.result[i] !== 16'd9) begin
        fails++;
        $display("FAIL b2b_second lane%0d valid=%0b got=%0d want 1/9",
                 i, bus.out_valid, bus.result[i]);
      end
    end
    $display("[TB] txn back_to_back done");
  endtask

  task automatic test_reset_midstream();
    int av [N];
    int bv [N];
    for (int i = 0; i < N; i++) begin
      av[i] = 10 + i;
      bv[i] = 3;
    end
    rst = 1'b1;
    drive(1'b1, av, bv);
    step();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_valid got=%0b want=0", bus.out_valid);
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (bus.result[i] !== '0) begin
        fails++;
        $display("FAIL midrst lane%0d got=%0d want=0", i, bus.result[i]);
      end
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < N; i++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.result[i] !== 16'(30 + 3 * i)) begin
        fails++;
        $display("FAIL post_rst lane%0d valid=%0b got=%0d want=%0d",
                 i, bus.out_valid, bus.result[i], 30 + 3 * i);
      end
    end
    $display("[TB] txn reset_midstream done");
  endtask

  task automatic test_lane_isolation();
    int av [N];
    int bv [N];
    av = '{1, 0, 0, 0, 0, 0, 0, 0};
    bv = '{5, 9, 9, 9, 9, 9, 9, 9};
    drive(1'b1, av, bv);
    step();
    for (int i = 0; i < N; i++) begin
      tests++;
      if (bus.result[i] !== 16'((i == 0) ? 5 : 0)) begin
        fails++;
        $display("FAIL isolation lane%0d got=%0d want=%0d", i, bus.result[i], (i == 0) ? 5 : 0);
      end
    end
    $display("[TB] txn lane_isolation done");
  endtask

  task automatic test_random();
    int av [N];
    int bv [N];
    int bad;
    for (int c = 0; c < 1000; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        av[i] = int'($urandom_range(0, 255));
        bv[i] = int'($urandom_range(0, 255));
      end
      drive(1'($urandom_range(0, 1)), av, bv);
      step();
      bad = 0;
      tests++;
      if (bus.out_valid !== m_valid) bad++;
      for (int i = 0; i < N; i++) begin
        if (bus.result[i] !== m_res[i]) bad++;
      end
      if (bad != 0) begin
        fails++;
        $display("FAIL random cyc%0d valid=%0b want=%0b r0=%0d want=%0d r7=%0d want=%0d",
                 c, bus.out_valid, m_valid, bus.result[0], m_res[0],
                 bus.result[N-1], m_res[N-1]);
      end else begin
        $display("[TB] txn rand%0d rst=%0b valid=%0b r0=%0d", c, rst, m_valid, m_res[0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.a[i] = '0;
      bus.b[i] = '0;
      m_res[i] = '0;
    end
    m_valid = 1'b0;
    test_reset();
    test_pattern();
    test_extremes();
    test_back_to_back();
    test_reset_midstream();
    test_lane_isolation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_elementwise_multiplication
